// File: rtl/fa_response_checker.sv
// Receive-side checker for the 1-bit full adder: compares each valid response with
// a+b+cin, counts mismatches, records the first failure and tracks vector coverage.
module fa_response_checker #(
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vld,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       cov_mask,
    output logic             first_err_vld,
    output logic [2:0]       first_err_vec
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] StallLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [7:0]        cov_q, cov_d;
    logic              fev_q, fev_d;
    logic [2:0]        fvec_q, fvec_d;
    logic              tmo_q, tmo_d;
    logic              pass_q, pass_d;
    logic [TW-1:0]     stall_q, stall_d;

    logic [2:0] idx;
    logic [1:0] golden;
    logic       mismatch;

    assign idx      = {b, a, cin};
    assign golden   = {1'b0, a} + {1'b0, b} + {1'b0, cin};
    assign mismatch = (golden != {cout, sum});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            err_q   <= '0;
            cov_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
            tmo_q   <= 1'b0;
            pass_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            fev_q   <= fev_d;
            fvec_q  <= fvec_d;
            tmo_q   <= tmo_d;
            pass_q  <= pass_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cov_d   = cov_q;
        fev_d   = fev_q;
        fvec_d  = fvec_q;
        tmo_d   = tmo_q;
        pass_d  = pass_q;
        stall_d = stall_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StCheck;
                    err_d   = '0;
                    cov_d   = '0;
                    fev_d   = 1'b0;
                    fvec_d  = '0;
                    tmo_d   = 1'b0;
                    pass_d  = 1'b0;
                    stall_d = '0;
                end
            end
            StCheck: begin
                if (vld) begin
                    cov_d   = cov_q | (8'd1 << idx);
                    stall_d = '0;
                    if (mismatch) begin
                        if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fvec_d = idx;
                        end
                    end
                    // Pass judged on the count that already includes this sample.
                    if (cov_d == 8'hFF) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    stall_d = stall_q + TW'(1);
                    if (stall_q == StallLast) begin
                        state_d = StDone;
                        tmo_d   = 1'b1;
                        pass_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q == StCheck);
        done          = (state_q == StDone);
        pass          = pass_q;
        timeout       = tmo_q;
        err_cnt       = err_q;
        cov_mask      = cov_q;
        first_err_vld = fev_q;
        first_err_vec = fvec_q;
    end

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: table-driven run sequences plus hand-written
// timeout, saturation and asynchronous-reset sequences.
module tb_fa_response_checker;

    logic clk = 1'b0;
    logic rst_n, start, start2, vld, a, b, cin, sum, cout;
    logic busy, done, pass, timeout, first_err_vld;
    logic [7:0] err_cnt, cov_mask;
    logic [2:0] first_err_vec;
    logic busy2, done2, pass2, timeout2, first_err_vld2;
    logic [1:0] err_cnt2;
    logic [7:0] cov_mask2;
    logic [2:0] first_err_vec2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fa_response_checker #(.ERR_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .cov_mask(cov_mask), .first_err_vld(first_err_vld),
        .first_err_vec(first_err_vec)
    );

    fa_response_checker #(.ERR_W(2), .TIMEOUT(64)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .vld(vld), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .busy(busy2), .done(done2), .pass(pass2),
        .timeout(timeout2), .err_cnt(err_cnt2), .cov_mask(cov_mask2),
        .first_err_vld(first_err_vld2), .first_err_vec(first_err_vec2)
    );

    typedef struct {
        bit         st;
        bit         v;
        int         idx;
        bit         fs;
        bit         fc;
        bit         e_busy;
        bit         e_done;
        bit         e_pass;
        int         e_err;
        logic [7:0] e_cov;
        bit         e_fvld;
        int         e_fvec;
    } step_t;

    step_t tbl[$];

    function automatic void add(bit st, bit v, int idx, bit fs, bit fc, bit eb, bit ed,
                                bit ep, int ee, logic [7:0] ec, bit efv, int efe);
        step_t s;
        s = '{st, v, idx, fs, fc, eb, ed, ep, ee, ec, efv, efe};
        tbl.push_back(s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive vector idx={b,a,cin} with a correct response, optionally corrupted.
    task automatic set_vec(input int idx, input bit fs, input bit fc);
        logic [2:0] v;
        logic [1:0] s;
        v    = idx[2:0];
        b    = v[2];
        a    = v[1];
        cin  = v[0];
        s    = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
        sum  = s[0] ^ fs;
        cout = s[1] ^ fc;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {12'd0, busy, done, pass, timeout, err_cnt, cov_mask, first_err_vld,
                 first_err_vec}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; vld = 1'b0;
        set_vec(0, 1'b0, 1'b0);

        // vld in IDLE ignored
        add(0, 1, 7, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        // Test 1: clean run
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h01, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h03, 0, 0);
        add(0, 1, 2, 0, 0, 1, 0, 0, 0, 8'h07, 0, 0);
        add(0, 1, 3, 0, 0, 1, 0, 0, 0, 8'h0F, 0, 0);
        add(0, 1, 4, 0, 0, 1, 0, 0, 0, 8'h1F, 0, 0);
        add(0, 1, 5, 0, 0, 1, 0, 0, 0, 8'h3F, 0, 0);
        add(0, 1, 6, 0, 0, 1, 0, 0, 0, 8'h7F, 0, 0);
        add(0, 1, 7, 0, 0, 0, 1, 1, 0, 8'hFF, 0, 0);
        // vld in DONE ignored
        add(0, 1, 0, 1, 0, 0, 1, 1, 0, 8'hFF, 0, 0);
        // Test 2: restart from DONE, sum inverted on idx 5
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h01, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h03, 0, 0);
        add(0, 1, 2, 0, 0, 1, 0, 0, 0, 8'h07, 0, 0);
        add(0, 1, 3, 0, 0, 1, 0, 0, 0, 8'h0F, 0, 0);
        add(0, 1, 4, 0, 0, 1, 0, 0, 0, 8'h1F, 0, 0);
        add(0, 1, 5, 1, 0, 1, 0, 0, 1, 8'h3F, 1, 5);
        add(0, 1, 6, 0, 0, 1, 0, 0, 1, 8'h7F, 1, 5);
        add(0, 1, 7, 0, 0, 0, 1, 0, 1, 8'hFF, 1, 5);
        // Test 6: start in DONE clears; start in CHECK is ignored
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0, 0, 1, 8'h01, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 1, 8'h01, 1, 0);
        add(0, 1, 2, 0, 1, 1, 0, 0, 2, 8'h05, 1, 0);

        #2;
        chk_zero("reset_state");
        #5;
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            start = tbl[i].st;
            vld   = tbl[i].v;
            set_vec(tbl[i].idx, tbl[i].fs, tbl[i].fc);
            tick();
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("row%0d pass", i), 32'(pass), 32'(tbl[i].e_pass));
            chk($sformatf("row%0d err_cnt", i), 32'(err_cnt), tbl[i].e_err);
            chk($sformatf("row%0d cov_mask", i), 32'(cov_mask), 32'(tbl[i].e_cov));
            chk($sformatf("row%0d first_err_vld", i), 32'(first_err_vld),
                32'(tbl[i].e_fvld));
            chk($sformatf("row%0d first_err_vec", i), 32'(first_err_vec), tbl[i].e_fvec);
        end
        start = 1'b0;
        vld   = 1'b0;

        // Test 3: stall timeout after idx 0..6 plus a bad repeat of idx 3
        #3 rst_n = 1'b0;
        #1 chk_zero("t3_async_reset");
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vld   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            set_vec(k, 1'b0, 1'b0);
            tick();
        end
        set_vec(3, 1'b0, 1'b1);
        tick();
        vld = 1'b0;
        repeat (63) tick();
        chk("t3_not_done_at_63", {30'd0, busy, done}, 32'b10);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_pass", 32'(pass), 32'd0);
        chk("t3_cov", 32'(cov_mask), 32'h7F);
        chk("t3_err", 32'(err_cnt), 32'd1);
        chk("t3_fvld", 32'(first_err_vld), 32'd1);
        chk("t3_fvec", 32'(first_err_vec), 32'd3);

        // Test 4: ERR_W=2 saturation, dut stays in DONE and ignores vld
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        vld    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_vec(0, 1'b1, 1'b0);
            tick();
        end
        chk("t4_err_sat", 32'(err_cnt2), 32'd3);
        chk("t4_busy_mid", 32'(busy2), 32'd1);
        for (int k = 1; k < 8; k++) begin
            set_vec(k, 1'b0, 1'b0);
            tick();
        end
        vld = 1'b0;
        chk("t4_done", 32'(done2), 32'd1);
        chk("t4_err_final", 32'(err_cnt2), 32'd3);
        chk("t4_pass", 32'(pass2), 32'd0);
        chk("t4_fvec", {28'd0, first_err_vld2, first_err_vec2}, {28'd0, 1'b1, 3'd0});
        chk("t4_dut1_ignored", 32'(cov_mask), 32'h7F);

        // Test 5: asynchronous reset mid-run, between clock edges
        start = 1'b1;
        tick();
        start = 1'b0;
        vld   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_vec(k, 1'b0, 1'b0);
            tick();
        end
        chk("t5_cov_before", 32'(cov_mask), 32'h0F);
        #3 rst_n = 1'b0;
        #1 chk_zero("t5_reset_no_edge");
        #2 rst_n = 1'b1;
        set_vec(4, 1'b0, 1'b0);
        tick();
        tick();
        chk("t5_vld_ignored", {23'd0, busy, cov_mask}, 32'd0);
        vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
